// File: rtl/zuse_link_pkg.sv
// tinyZuse host link: opcodes, command bytes and the
// helpers that turn a latched request into its byte sequence.
package zuse_link_pkg;

    localparam int EXP_W = 7;
    localparam int MAN_W = 15;

    localparam logic [2:0] OP_SET1 = 3'd0;
    localparam logic [2:0] OP_SET2 = 3'd1;
    localparam logic [2:0] OP_RD1  = 3'd2;
    localparam logic [2:0] OP_RD2  = 3'd3;
    localparam logic [2:0] OP_RDS  = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_CALC = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [7:0] CMD_SETR1  = 8'h81;
    localparam logic [7:0] CMD_SETR2  = 8'h82;
    localparam logic [7:0] CMD_READR1 = 8'h83;
    localparam logic [7:0] CMD_READR2 = 8'h84;
    localparam logic [7:0] CMD_READRS = 8'h85;
    localparam logic [7:0] CMD_ADD    = 8'h89;

    function automatic logic [7:0] pay_byte(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] m,
        input logic [1:0]       k
    );
        logic [7:0] b;
        case (k)
            2'd0:    b = {1'b0, e};
            2'd1:    b = m[14:7];
            default: b = {m[6:0], 1'b0};
        endcase
        return b;
    endfunction

    // CALC is SET1 (0-3), SET2 (4-7), ADD (8), READRS (9)
    function automatic logic [7:0] seq_byte(
        input logic [2:0]       op,
        input logic [3:0]       idx,
        input logic [EXP_W-1:0] e1,
        input logic [MAN_W-1:0] m1,
        input logic [EXP_W-1:0] e2,
        input logic [MAN_W-1:0] m2
    );
        logic [1:0] k;
        logic [7:0] b;
        k = idx[1:0] - 2'd1;
        b = 8'h00;
        case (op)
            OP_SET1: b = (idx == 4'd0) ? CMD_SETR1 : pay_byte(e1, m1, k);
            OP_SET2: b = (idx == 4'd0) ? CMD_SETR2 : pay_byte(e2, m2, k);
            OP_RD1:  b = CMD_READR1;
            OP_RD2:  b = CMD_READR2;
            OP_RDS:  b = CMD_READRS;
            OP_ADD:  b = CMD_ADD;
            OP_CALC: begin
                if (idx == 4'd0)      b = CMD_SETR1;
                else if (idx < 4'd4)  b = pay_byte(e1, m1, k);
                else if (idx == 4'd4) b = CMD_SETR2;
                else if (idx < 4'd8)  b = pay_byte(e2, m2, k);
                else if (idx == 4'd8) b = CMD_ADD;
                else                  b = CMD_READRS;
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] seq_last(input logic [2:0] op);
        logic [3:0] n;
        case (op)
            OP_SET1, OP_SET2: n = 4'd3;
            OP_CALC:          n = 4'd9;
            default:          n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_read(input logic [2:0] op);
        return (op == OP_RD1) || (op == OP_RD2) ||
               (op == OP_RDS) || (op == OP_CALC);
    endfunction

endpackage

// File: rtl/zuse_tx_handshake.sv
// One-byte send handshake towards a uart_tx-style transmitter:
// load, start pulse, busy acknowledge, drain, inter-byte gap.
module zuse_tx_handshake #(
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);

    typedef enum logic [2:0] {
        H_IDLE, H_LOAD, H_PULSE, H_ACK, H_DRAIN, H_GAP
    } hs_state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(3);

    hs_state_t      state;
    logic [CW-1:0]  cnt;

    assign byte_ready = (state == H_IDLE);
    assign byte_done  = (state == H_GAP) && (cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= H_IDLE;
            cnt      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            case (state)
                H_IDLE: if (byte_valid) begin
                    tx_data <= byte_data;
                    state   <= H_LOAD;
                end
                H_LOAD: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    state    <= H_PULSE;
                end
                H_PULSE: begin
                    tx_start <= 1'b0;
                    cnt      <= '0;
                    state    <= H_ACK;
                end
                // a transmitter that never raises busy still gets credit
                H_ACK: begin
                    if (tx_busy) begin
                        state <= H_DRAIN;
                    end else if (cnt == ACK_LAST) begin
                        cnt   <= '0;
                        state <= H_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                H_DRAIN: if (!tx_busy) begin
                    cnt   <= '0;
                    state <= H_GAP;
                end
                H_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= H_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= H_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/zuse_host_link.sv
// tinyZuse host initiator: serializes one request into command
// bytes and reassembles the three-byte read response.
module zuse_host_link
    import zuse_link_pkg::*;
#(
    parameter int ADD_WAIT   = 64,
    parameter int RX_TIMEOUT = 50000,
    parameter int GAP        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [EXP_W-1:0] req_e1,
    input  logic [MAN_W-1:0] req_m1,
    input  logic [EXP_W-1:0] req_e2,
    input  logic [MAN_W-1:0] req_m2,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic             rsp_valid,
    output logic [EXP_W-1:0] rsp_e,
    output logic [MAN_W-1:0] rsp_m,
    output logic             rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_ADDWAIT, S_RECV, S_DONE
    } state_t;

    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int WW = $clog2(ADD_WAIT + 1);
    localparam logic [TW-1:0] T_TRIG = TW'(RX_TIMEOUT - 1);
    localparam logic [WW-1:0] W_LAST = WW'(ADD_WAIT - 1);

    state_t           state;
    logic [2:0]       op;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic [3:0]       idx;
    logic [1:0]       bidx;
    logic [6:0]       b0;
    logic [7:0]       b1;
    logic [TW-1:0]    tcnt;
    logic [WW-1:0]    wcnt;

    logic       byte_valid, byte_ready, byte_done;
    logic [7:0] byte_data;

    assign byte_data  = seq_byte(op, idx, e1, m1, e2, m2);
    assign byte_valid = (state == S_SEND) && byte_ready;

    zuse_tx_handshake #(.GAP(GAP)) u_hs (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op        <= 3'd0;
            e1        <= '0;
            m1        <= '0;
            e2        <= '0;
            m2        <= '0;
            idx       <= 4'd0;
            bidx      <= 2'd0;
            b0        <= 7'd0;
            b1        <= 8'd0;
            tcnt      <= '0;
            wcnt      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_e     <= '0;
            rsp_m     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid && req_ready) begin
                    op        <= req_op;
                    e1        <= req_e1;
                    m1        <= req_m1;
                    e2        <= req_e2;
                    m2        <= req_m2;
                    idx       <= 4'd0;
                    bidx      <= 2'd0;
                    req_ready <= 1'b0;
                    if (req_op == OP_RSVD) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_SEND;
                    end
                end
                S_SEND: if (byte_done) begin
                    if (idx != seq_last(op)) begin
                        idx   <= idx + 4'd1;
                        wcnt  <= '0;
                        state <= (op == OP_CALC && idx == 4'd8) ?
                                 S_ADDWAIT : S_SEND;
                    end else if (is_read(op)) begin
                        // a byte landing on the switch into RECV counts
                        tcnt  <= TW'(1);
                        state <= S_RECV;
                        if (rx_done) begin
                            b0   <= rx_data[6:0];
                            bidx <= 2'd1;
                        end
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_ADDWAIT: begin
                    if (wcnt == W_LAST) state <= S_SEND;
                    else                wcnt  <= wcnt + WW'(1);
                end
                S_RECV: begin
                    if (rx_done) begin
                        tcnt <= TW'(1);
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd0) b0 <= rx_data[6:0];
                        if (bidx == 2'd1) b1 <= rx_data;
                        if (bidx == 2'd2) begin
                            rsp_e     <= b0;
                            rsp_m     <= {b1, rx_data[7:1]};
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            state     <= S_DONE;
                        end
                    end else if (tcnt == T_TRIG) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zuse_host_link.sv
// Bench for zuse_host_link: vector table plus scoreboard queues
// fed by a transmitter model and response monitor.
module tb_zuse_host_link;

    localparam int TB_TIMEOUT = 400;
    localparam int TB_ADDWAIT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [6:0]  req_e1 = '0, req_e2 = '0;
    logic [14:0] req_m1 = '0, req_m2 = '0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        rsp_valid;
    logic [6:0]  rsp_e;
    logic [14:0] rsp_m;
    logic        rsp_err;

    always #5 clk = ~clk;

    zuse_host_link #(
        .ADD_WAIT   (TB_ADDWAIT),
        .RX_TIMEOUT (TB_TIMEOUT),
        .GAP        (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_e1    (req_e1),
        .req_m1    (req_m1),
        .req_e2    (req_e2),
        .req_m2    (req_m2),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rsp_valid (rsp_valid),
        .rsp_e     (rsp_e),
        .rsp_m     (rsp_m),
        .rsp_err   (rsp_err)
    );

    typedef struct packed {
        logic        err;
        logic [6:0]  e;
        logic [14:0] m;
    } rsp_t;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [6:0]  e1;
        logic [14:0] m1;
        logic [6:0]  e2;
        logic [14:0] m2;
        int          ntx;
        logic [79:0] txb;
        int          nrx;
        logic [23:0] rxb;
        rsp_t        rsp;
    } vec_t;

    int   tests = 0, fails = 0;
    int   cyc = 0, n_tx = 0, n_rsp = 0;
    int   last_rsp_cyc = 0, rx_cyc = 0, busy_cnt = 0;
    logic model_busy = 1'b0, force_busy = 1'b0;
    logic [7:0] exp_txq[$];
    rsp_t       exp_rspq[$];
    int         start_cycs[$];
    vec_t       vecs[8];

    assign tx_busy = model_busy | force_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string n, input logic [2:0] op,
        input logic [6:0] e1, input logic [14:0] m1,
        input logic [6:0] e2, input logic [14:0] m2,
        input int ntx, input logic [79:0] txb,
        input int nrx, input logic [23:0] rxb,
        input rsp_t r);
        vec_t v;
        v.name = n;   v.op = op;
        v.e1 = e1;    v.m1 = m1;
        v.e2 = e2;    v.m2 = m2;
        v.ntx = ntx;  v.txb = txb;
        v.nrx = nrx;  v.rxb = rxb;
        v.rsp = r;
        return v;
    endfunction

    // transmitter model and output scoreboard
    initial begin
        logic [7:0] eb;
        rsp_t       er;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                n_tx++;
                start_cycs.push_back(cyc);
                busy_cnt = 8;
                check("tx_expected", 32'(exp_txq.size() > 0), 1);
                if (exp_txq.size() > 0) begin
                    eb = exp_txq.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(eb));
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            model_busy = (busy_cnt > 0);
            if (rst_n && rsp_valid) begin
                n_rsp++;
                last_rsp_cyc = cyc;
                check("rsp_expected", 32'(exp_rspq.size() > 0), 1);
                if (exp_rspq.size() > 0) begin
                    er = exp_rspq.pop_front();
                    check("rsp", 32'({rsp_err, rsp_e, rsp_m}), 32'(er));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int b0, r0, n;
        b0 = n_tx;
        r0 = n_rsp;
        exp_txq.delete();
        exp_rspq.delete();
        start_cycs.delete();
        for (int i = 0; i < v.ntx; i++)
            exp_txq.push_back(v.txb[79-8*i -: 8]);
        exp_rspq.push_back(v.rsp);
        check({v.name, "_ready"}, 32'(req_ready), 1);
        @(posedge clk); #1;
        req_op = v.op;
        req_e1 = v.e1; req_m1 = v.m1;
        req_e2 = v.e2; req_m2 = v.m2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check({v.name, "_busy"}, 32'(req_ready), 0);
        if (v.op == 3'd7)
            check({v.name, "_rsvd_rsp"}, 32'(rsp_valid), 1);
        // stray byte while the request is in flight
        @(posedge clk); #1;
        rx_data = 8'hEE; rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        n = 0;
        while (n_tx - b0 < v.ntx && n < 2000) begin
            @(negedge clk); n++;
        end
        check({v.name, "_tx_n"}, 32'(n_tx - b0), 32'(v.ntx));
        repeat (20) @(posedge clk);
        for (int i = 0; i < v.nrx; i++) begin
            #1;
            rx_data = v.rxb[23-8*i -: 8];
            rx_done = 1'b1;
            rx_cyc = cyc;
            @(posedge clk); #1;
            rx_done = 1'b0;
            repeat (2) @(posedge clk);
        end
        n = 0;
        while (n_rsp == r0 && n < TB_TIMEOUT + 500) begin
            @(negedge clk); n++;
        end
        if (v.rsp.err && v.nrx > 0)
            check({v.name, "_tmo_cyc"},
                  32'(last_rsp_cyc - rx_cyc), 32'(TB_TIMEOUT));
        if (v.op == 3'd6 && start_cycs.size() == 10)
            check({v.name, "_addwait"},
                  32'(start_cycs[9] - start_cycs[8] > TB_ADDWAIT), 1);
        repeat (5) @(negedge clk);
        check({v.name, "_rsp_n"}, 32'(n_rsp - r0), 1);
        check({v.name, "_tx_left"}, 32'(exp_txq.size()), 0);
        check({v.name, "_ready_back"}, 32'(req_ready), 1);
    endtask

    initial begin
        int b0, bad, n;
        vecs[0] = mk("set1", 3'd0, 7'h25, 15'h4A3B, 7'h00, 15'h0000,
                     4, 80'h8125_9476_0000_0000_0000, 0, 24'h0,
                     {1'b0, 7'h00, 15'h0000});
        vecs[1] = mk("rds", 3'd4, 7'h00, 15'h0000, 7'h00, 15'h0000,
                     1, 80'h8500_0000_0000_0000_0000, 3, 24'h928003,
                     {1'b0, 7'h12, 15'h4001});
        vecs[2] = mk("set2", 3'd1, 7'h00, 15'h0000, 7'h7F, 15'h7FFF,
                     4, 80'h827F_FFFE_0000_0000_0000, 0, 24'h0,
                     {1'b0, 7'h12, 15'h4001});
        vecs[3] = mk("rd2", 3'd3, 7'h00, 15'h0000, 7'h00, 15'h0000,
                     1, 80'h8400_0000_0000_0000_0000, 3, 24'h851235,
                     {1'b0, 7'h05, 15'h091A});
        vecs[4] = mk("add", 3'd5, 7'h00, 15'h0000, 7'h00, 15'h0000,
                     1, 80'h8900_0000_0000_0000_0000, 0, 24'h0,
                     {1'b0, 7'h05, 15'h091A});
        vecs[5] = mk("rsvd", 3'd7, 7'h00, 15'h0000, 7'h00, 15'h0000,
                     0, 80'h0, 0, 24'h0,
                     {1'b1, 7'h05, 15'h091A});
        vecs[6] = mk("calc", 3'd6, 7'h01, 15'h4000, 7'h01, 15'h4000,
                     10, 80'h8101_8000_8201_8000_8985, 3, 24'h3FAA55,
                     {1'b0, 7'h3F, 15'h552A});
        vecs[7] = mk("rd1_tmo", 3'd2, 7'h00, 15'h0000, 7'h00, 15'h0000,
                     1, 80'h8300_0000_0000_0000_0000, 2, 24'h112200,
                     {1'b1, 7'h3F, 15'h552A});

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl",
              32'({req_ready, tx_start, rsp_valid, rsp_err, tx_data}),
              32'h800);
        check("reset_rsp", 32'({rsp_e, rsp_m}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // transmitter held busy: the first byte must wait in place
        force_busy = 1'b1;
        fork
            run_vec(mk("hold", 3'd1, 7'h00, 15'h0000, 7'h33, 15'h0155,
                       4, 80'h8233_02AA_0000_0000_0000, 0, 24'h0,
                       {1'b0, 7'h3F, 15'h552A}));
            begin
                b0 = n_tx;
                bad = 0;
                repeat (6) @(negedge clk);
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    if (tx_data !== 8'h82) bad++;
                end
                check("hold_no_start", 32'(n_tx - b0), 0);
                check("hold_tx_data", 32'(bad), 0);
                force_busy = 1'b0;
            end
        join

        // asynchronous reset in the middle of a CALC
        exp_txq.delete();
        exp_rspq.delete();
        for (int i = 0; i < 10; i++)
            exp_txq.push_back(vecs[6].txb[79-8*i -: 8]);
        b0 = n_tx;
        @(posedge clk); #1;
        req_op = 3'd6;
        req_e1 = 7'h01; req_m1 = 15'h4000;
        req_e2 = 7'h01; req_m2 = 15'h4000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (n_tx - b0 < 5 && n < 2000) begin
            @(negedge clk); n++;
        end
        check("mid_calc_tx_n", 32'(n_tx - b0), 5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctl",
              32'({req_ready, tx_start, rsp_valid, rsp_err, tx_data}),
              32'h800);
        check("async_rst_rsp", 32'({rsp_e, rsp_m}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_txq.delete();
        exp_rspq.delete();
        repeat (20) @(negedge clk);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end, %0d tests so far", tests);
        $fatal(1, "watchdog");
    end

endmodule
